axis_rr_arbiter: RTL and testbench

//  Packet-level round-robin arbiter/mux that shares one AXI-Stream master port among N_PORTS slave streams.

---
 rtl/axis_rr_arbiter.sv | 57 +++++
 tb/tb_axis_rr_arbiter.sv | 134 +++++++++++++
 2 files changed

// File: rtl/axis_rr_arbiter.sv
// axis_rr_arbiter: packet-level round-robin AXI-Stream mux sharing one master among N_PORTS slaves.
module axis_rr_arbiter #(
    parameter int N_PORTS = 4,
    parameter int DATA_W  = 32
) (
    input  logic                         aclk,
    input  logic                         aresetn,
    input  logic [N_PORTS*DATA_W-1:0]    s_tdata,
    input  logic [N_PORTS-1:0]           s_tvalid,
    input  logic [N_PORTS-1:0]           s_tlast,
    output logic [N_PORTS-1:0]           s_tready,
    output logic [DATA_W-1:0]            m_tdata,
    output logic                         m_tvalid,
    output logic                         m_tlast,
    input  logic                         m_tready,
    output logic [$clog2(N_PORTS)-1:0]   m_tid
);
    localparam int ID_W = $clog2(N_PORTS);
    typedef enum logic {IDLE, BUSY} state_t;
    state_t          r_state;
    logic [ID_W-1:0] r_grant;
    logic [ID_W-1:0] r_last_grant;
    logic [ID_W-1:0] w_pick;
    logic [ID_W-1:0] w_idx;
    logic            w_act;
    // Walk the rotation from farthest to nearest so the port closest after last_grant wins.
    always_comb begin
        w_pick = '0;
        w_idx  = '0;
        for (int k = N_PORTS; k >= 1; k--) begin
            w_idx = ID_W'((int'(r_last_grant) + k) % N_PORTS);
            if (s_tvalid[w_idx]) w_pick = w_idx;
        end
    end
    // Gating with aresetn keeps any beat from completing while reset is held.
    assign w_act    = aresetn && (r_state == BUSY);
    assign m_tvalid = w_act && s_tvalid[r_grant];
    assign m_tlast  = w_act && s_tlast[r_grant];
    assign m_tdata  = w_act ? s_tdata[r_grant*DATA_W +: DATA_W] : '0;
    assign m_tid    = w_act ? r_grant : '0;
    assign s_tready = (w_act && m_tready) ? (N_PORTS'(1) << r_grant) : '0;
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_state      <= IDLE;
            r_grant      <= '0;
            r_last_grant <= ID_W'(N_PORTS - 1);
        end else if (r_state == IDLE) begin
            if (|s_tvalid) begin
                r_grant <= w_pick;
                r_state <= BUSY;
            end
        end else if (m_tvalid && m_tready && m_tlast) begin
            r_last_grant <= r_grant;
            r_state      <= IDLE;
        end
    end
endmodule

// File: tb/tb_axis_rr_arbiter.sv
// tb_axis_rr_arbiter: randomized and directed stimulus checked cycle by cycle against a behavioural model.
module tb_axis_rr_arbiter;
    localparam int N = 4;
    localparam int W = 32;
    logic             aclk = 1'b0;
    logic             aresetn = 1'b0;
    logic [N*W-1:0]   s_tdata = '0;
    logic [N-1:0]     s_tvalid = '0;
    logic [N-1:0]     s_tlast = '0;
    logic [N-1:0]     s_tready;
    logic [W-1:0]     m_tdata;
    logic             m_tvalid;
    logic             m_tlast;
    logic             m_tready = 1'b1;
    logic [1:0]       m_tid;
    int n_cmp = 0;
    int n_bad = 0;
    logic [N-1:0] en = '0;
    int len = 1, pv = 100, pr = 100;
    int rem [N];
    bit busy = 0;
    int g = 0, lg = N - 1;
    int tid_log [$];
    bit last_log [$];
    always #5 aclk = ~aclk;
    axis_rr_arbiter #(.N_PORTS(N), .DATA_W(W)) dut (
        .aclk(aclk), .aresetn(aresetn), .s_tdata(s_tdata), .s_tvalid(s_tvalid),
        .s_tlast(s_tlast), .s_tready(s_tready), .m_tdata(m_tdata), .m_tvalid(m_tvalid),
        .m_tlast(m_tlast), .m_tready(m_tready), .m_tid(m_tid)
    );
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask
    // Slaves obey AXIS: a presented beat is held until accepted; packet length len (0 = random 1..4).
    task automatic drive(input logic [N-1:0] hs);
        for (int i = 0; i < N; i++) begin
            if (hs[i]) rem[i]--;
            if (s_tvalid[i] && !hs[i]) continue;
            if (rem[i] == 0) rem[i] = (len != 0) ? len : int'($urandom_range(1, 4));
            s_tvalid[i] = en[i] && ($urandom_range(1, 100) <= pv);
            s_tdata[i*W +: W] = $urandom;
            s_tlast[i] = (rem[i] == 1);
        end
        m_tready = ($urandom_range(1, 100) <= pr);
    endtask
    task automatic cycle();
        logic [N-1:0] exp_rdy;
        bit act;
        @(negedge aclk);
        act = aresetn && busy;
        exp_rdy = (act && m_tready) ? N'(1 << g) : '0;
        check("m_tvalid", m_tvalid, act && s_tvalid[g]);
        check("m_tdata", m_tdata, act ? s_tdata[g*W +: W] : '0);
        check("m_tlast", m_tlast, act && s_tlast[g]);
        check("m_tid", m_tid, act ? g : 0);
        check("s_tready", s_tready, exp_rdy);
        if (m_tvalid && m_tready) begin
            tid_log.push_back(int'(m_tid));
            last_log.push_back(m_tlast);
        end
        @(posedge aclk);
        if (!aresetn) begin
            busy = 0; g = 0; lg = N - 1;
        end else if (!busy) begin
            for (int k = 1; k <= N; k++)
                if (s_tvalid[(lg + k) % N]) begin
                    g = (lg + k) % N;
                    busy = 1;
                    break;
                end
        end else if (s_tvalid[g] && m_tready && s_tlast[g]) begin
            lg = g;
            busy = 0;
        end
        #1;
        if (aresetn) drive(s_tvalid & exp_rdy);
        else begin
            s_tvalid = '0;
            for (int i = 0; i < N; i++) rem[i] = 0;
        end
    endtask
    task automatic do_reset();
        aresetn = 1'b0;
        repeat (2) cycle();
        aresetn = 1'b1;
    endtask
    task automatic run(input logic [N-1:0] e, input int l, input int v, input int r, input int n);
        en = e; len = l; pv = v; pr = r;
        tid_log.delete();
        last_log.delete();
        repeat (n) cycle();
    endtask
    function automatic int tid_at(input int i);
        return (tid_log.size() > i) ? tid_log[i] : -1;
    endfunction
    initial begin
        int seq1 [9] = '{0, 0, 1, 1, 2, 2, 3, 3, 0};
        int n2;
        for (int i = 0; i < N; i++) rem[i] = 0;
        do_reset();
        run(4'b1111, 2, 100, 100, 16);
        for (int i = 0; i < 9; i++) check($sformatf("rr_seq[%0d]", i), 64'(tid_at(i)), 64'(seq1[i]));
        do_reset();
        run(4'b0100, 3, 100, 100, 13);
        check("lone_beats", 64'(tid_log.size()), 64'd9);
        n2 = 0;
        foreach (tid_log[i]) if (tid_log[i] == 2) n2++;
        check("lone_tid2", 64'(n2), 64'(tid_log.size()));
        do_reset();
        run(4'b0010, 4, 100, 100, 4);
        check("pre_reset_port1", 64'(tid_at(0)), 64'd1);
        do_reset();
        run(4'b0011, 2, 100, 100, 4);
        check("post_reset_first", 64'(tid_at(0)), 64'd0);
        do_reset();
        run(4'b1010, 1, 100, 100, 5);
        check("single_n", 64'(tid_log.size()), 64'd2);
        check("single_first", 64'(tid_at(0)), 64'd1);
        check("single_second", 64'(tid_at(1)), 64'd3);
        check("single_last", 64'((last_log.size() == 2) && last_log[0] && last_log[1]), 64'd1);
        do_reset();
        run(4'b1111, 0, 70, 60, 400);
        run(4'b1010, 0, 100, 25, 200);
        run(4'b0110, 0, 40, 90, 200);
        do_reset();
        run(4'b1111, 0, 85, 75, 300);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
